m_button_input: RTL and testbench

- Front-end producer of the 4-bit one-hot `w_user_input` code consumed by the game controller.
- Synchronizes, debounces and edge-detects the three raw Arty push buttons (INC / DEC / OK).
- Emits single-cycle one-hot command pulses, with auto-repeat on INC/DEC while a button is held.
- Sits between the board button pins and the game controller input.

---
 rtl/m_button_input.sv | 120 ++++++++++++
 tb/tb_m_button_input.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/m_button_input.sv
// Push-button front end: 2-flop sync, per-button debounce, press detection and
// INC/DEC auto-repeat, producing single-cycle one-hot commands for the game controller.
module m_button_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic [2:0] i_btn,
    output logic [3:0] o_user_input,
    output logic [2:0] o_btn_level
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [2:0]      r_s1, r_s2, r_level_d;
    logic [2:0]      w_level, w_press;
    logic            w_ok, w_dec, w_inc;
    logic            w_held, w_abort, w_switch, w_cnt_last, w_rep;
    state_t          r_state;
    logic            r_dir;          // 0 = INC, 1 = DEC
    logic [RP_W-1:0] r_rcnt;
    logic [3:0]      r_out;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic [DB_W-1:0] r_cnt;
        logic            r_lvl;
        always_ff @(posedge w_clk) begin
            if (w_rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_s2[g] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_lvl <= r_s2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
        assign w_level[g] = r_lvl;
    end

    // Lower-priority presses in the same cycle are dropped entirely, FSM included.
    assign w_press = w_level & ~r_level_d;
    assign w_ok    = w_press[2];
    assign w_dec   = w_press[1] & ~w_press[2];
    assign w_inc   = w_press[0] & ~w_press[1] & ~w_press[2];

    assign w_held     = r_dir ? w_level[1] : w_level[0];
    assign w_abort    = (r_state != IDLE) && (!w_held || (w_level[0] && w_level[1]));
    assign w_switch   = (r_state != IDLE) && (r_dir ? w_inc : w_dec);
    assign w_cnt_last = (r_state == DELAY)  ? (r_rcnt == DLY_LAST) :
                        (r_state == REPEAT) ? (r_rcnt == PER_LAST) : 1'b0;
    assign w_rep      = w_cnt_last && !w_abort && !w_switch;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_level_d <= '0;
            r_state   <= IDLE;
            r_dir     <= 1'b0;
            r_rcnt    <= '0;
            r_out     <= '0;
        end else begin
            r_level_d <= w_level;
            if (w_ok)       r_out <= 4'b0100;
            else if (w_dec) r_out <= 4'b0010;
            else if (w_inc) r_out <= 4'b0001;
            else if (w_rep) r_out <= r_dir ? 4'b0010 : 4'b0001;
            else            r_out <= 4'b0000;

            case (r_state)
                IDLE: begin
                    r_rcnt <= '0;
                    if (w_inc || w_dec) begin
                        r_state <= DELAY;
                        r_dir   <= w_dec;
                    end
                end
                default: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_rcnt  <= '0;
                    end else if (w_switch) begin
                        r_state <= DELAY;
                        r_dir   <= ~r_dir;
                        r_rcnt  <= '0;
                    end else if (w_cnt_last) begin
                        r_state <= REPEAT;
                        r_rcnt  <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + RP_W'(1);
                    end
                end
            endcase
        end
    end

    assign o_user_input = r_out;
    assign o_btn_level  = w_level;

endmodule

// File: tb/tb_m_button_input.sv
// Bench for m_button_input: directed scenarios plus random button activity,
// all checked cycle-by-cycle against a timestamp-based behavioural model.
module tb_m_button_input;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       w_clk = 1'b0;
    logic       w_rst = 1'b1;
    logic [2:0] i_btn = 3'b000;
    logic [3:0] o_user_input;
    logic [2:0] o_btn_level;

    m_button_input #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .i_btn       (i_btn),
        .o_user_input(o_user_input),
        .o_btn_level (o_btn_level)
    );

    always #5 w_clk = ~w_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Model: raw sample history, levels flip once DEB consecutive synced samples
    // disagree; repeats are scheduled as absolute due times.
    logic [2:0] h[$];
    logic [2:0] m_lvl = '0, m_lvl_d = '0;
    logic [3:0] m_out = '0;
    bit         act = 0, mdir = 0;
    int         nxt = 0, t = 0;

    task automatic model_step(input logic rst, input logic [2:0] b);
        logic [2:0] press, nlvl;
        bit ok, dec, inc, rep, all;
        if (rst) begin
            h.delete();
            for (int i = 0; i <= DEB; i++) h.push_back(3'b000);
            m_lvl = '0; m_lvl_d = '0; m_out = '0; act = 0; mdir = 0; t++;
            return;
        end
        press = m_lvl & ~m_lvl_d;
        ok  = press[2];
        dec = press[1] && !ok;
        inc = press[0] && !ok && !press[1];
        rep = 0;
        if (act) begin
            if (!m_lvl[mdir] || (m_lvl[0] && m_lvl[1])) act = 0;
            else if ((!mdir && dec) || (mdir && inc)) begin mdir = dec; nxt = t + RD; end
            else if (t == nxt) begin rep = 1; nxt = t + RP; end
        end else if (inc || dec) begin
            act = 1; mdir = dec; nxt = t + RD;
        end
        m_out = ok ? 4'b0100 : dec ? 4'b0010 : inc ? 4'b0001 :
                rep ? (mdir ? 4'b0010 : 4'b0001) : 4'b0000;
        nlvl = m_lvl;
        for (int bb = 0; bb < 3; bb++) begin
            all = 1;
            for (int k = 1; k <= DEB; k++) if (h[k][bb] == m_lvl[bb]) all = 0;
            if (all) nlvl[bb] = ~m_lvl[bb];
        end
        h.push_front(b);
        void'(h.pop_back());
        m_lvl_d = m_lvl;
        m_lvl   = nlvl;
        t++;
    endtask

    task automatic cyc(input logic rst, input logic [2:0] b);
        w_rst = rst;
        i_btn = b;
        @(posedge w_clk);
        model_step(rst, b);
        @(negedge w_clk);
        chk("model_out", o_user_input, m_out);
        chk("model_lvl", o_btn_level, m_lvl);
    endtask

    initial begin
        int pulses, nok, ninc, seg, hold;
        int dec_t[$];
        logic [2:0] b;

        for (int i = 0; i <= DEB; i++) h.push_back(3'b000);
        @(negedge w_clk);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'b000);
            chk("rst_out", o_user_input, 4'b0000);
            chk("rst_lvl", o_btn_level, 3'b000);
        end
        for (int i = 3; i < 10; i++) cyc(1'b0, 3'b000);

        // INC tap: raised at cycle 10 for 5 cycles
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            cyc(1'b0, (i <= 5) ? 3'b001 : 3'b000);
            if (o_user_input != 4'b0000) pulses++;
            if (i == 6) chk("inc_lvl_t16", o_btn_level[0], 1'b1);
            if (i == 7) chk("inc_pulse_t17", o_user_input, 4'b0001);
        end
        chk("inc_pulse_count", pulses, 1);

        // OK glitch of 3 cycles
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, (i <= 3) ? 3'b100 : 3'b000);
            chk("glitch_lvl", o_btn_level, 3'b000);
            chk("glitch_out", o_user_input, 4'b0000);
        end

        // DEC held for 60 cycles: press at 7, repeats every RP after RD
        for (int i = 1; i <= 85; i++) begin
            cyc(1'b0, (i <= 60) ? 3'b010 : 3'b000);
            if (o_user_input == 4'b0010) dec_t.push_back(i);
            else chk("dec_other", o_user_input, 4'b0000);
        end
        chk("dec_count", dec_t.size(), 6);
        if (dec_t.size() == 6) begin
            chk("dec_p0", dec_t[0], 7);
            chk("dec_p20", dec_t[1], 27);
            chk("dec_p28", dec_t[2], 35);
            chk("dec_p36", dec_t[3], 43);
            chk("dec_p44", dec_t[4], 51);
            chk("dec_last", dec_t[5], 59);
        end

        // OK and INC together: OK only, INC repeat never starts
        nok = 0; ninc = 0;
        for (int i = 1; i <= 55; i++) begin
            cyc(1'b0, (i <= 45) ? 3'b101 : 3'b000);
            if (o_user_input == 4'b0100) nok++;
            if (o_user_input == 4'b0001) ninc++;
            if (i == 7) chk("ok_pulse", o_user_input, 4'b0100);
        end
        chk("ok_count", nok, 1);
        chk("ok_inc_count", ninc, 0);

        // Reset while INC is repeating
        for (int i = 1; i <= 40; i++) cyc(1'b0, 3'b001);
        cyc(1'b1, 3'b001);
        chk("midrst_out", o_user_input, 4'b0000);
        chk("midrst_lvl", o_btn_level, 3'b000);
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 3'b001);
            chk((i == 7) ? "fresh_inc" : "fresh_quiet", o_user_input, (i == 7) ? 4'b0001 : 4'b0000);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 3'b000);

        // Random activity with occasional resets and short glitches
        for (seg = 0; seg < 160; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                cyc(1'b1, 3'($urandom_range(0, 7)));
            end else begin
                b    = 3'($urandom_range(0, 7));
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 50);
                for (int i = 0; i < hold; i++) cyc(1'b0, b);
            end
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
